dmem_responder: RTL

Data-memory responder for the five-stage pipeline. It services load/store requests issued by the MEM stage with a fixed, parameterised access latency. It holds the pipeline via `stall` while an access is in flight, and returns size-aligned, optionally sign-extended load data. It is the memory-side end of the MEM-stage access interface. Byte order is big-endian: byte 0 is bits 31:24.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/dmem_lane_ctl.sv | 56 +++++
 rtl/dmem_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory path: access-size codes, FSM state
// constants and the alignment check used by the responder.
package mem_pkg;

  localparam logic [1:0] DSZ_BYTE = 2'b00;
  localparam logic [1:0] DSZ_HALF = 2'b01;
  localparam logic [1:0] DSZ_WORD = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Only the two low address bits matter for alignment; size 11 is always an error.
  function automatic logic misaligned(input logic [1:0] dsize, input logic [1:0] addr);
    logic bad;
    case (dsize)
      DSZ_BYTE: bad = 1'b0;
      DSZ_HALF: bad = addr[0];
      DSZ_WORD: bad = (addr != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_ctl.sv
// Big-endian byte-lane steering: write mask and replicated store data for the
// addressed lanes, plus extraction and extension of load data from a word.
module dmem_lane_ctl
  import mem_pkg::*;
(
  input  logic [1:0]  dsize,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic        loadext,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Mask bit i covers bits [8i+7:8i]; byte 0 (addr 00) is the most significant lane.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = wdata;
    case (dsize)
      DSZ_BYTE: begin
        byte_en    = 4'b1000 >> addr;
        wdata_lane = {4{wdata[7:0]}};
      end
      DSZ_HALF: begin
        byte_en    = addr[1] ? 4'b0011 : 4'b1100;
        wdata_lane = {2{wdata[15:0]}};
      end
      DSZ_WORD: byte_en = 4'b1111;
      default:  byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rword[31:24];
      2'd1:    byte_sel = rword[23:16];
      2'd2:    byte_sel = rword[15:8];
      default: byte_sel = rword[7:0];
    endcase
    half_sel = addr[1] ? rword[15:0] : rword[31:16];
  end

  always_comb begin
    case (dsize)
      DSZ_BYTE: load_data = {{24{loadext & byte_sel[7]}}, byte_sel};
      DSZ_HALF: load_data = {{16{loadext & half_sel[15]}}, half_sel};
      DSZ_WORD: load_data = rword;
      default:  load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage: latches one request,
// stalls the pipeline while it is in flight, then completes it in a single RESP cycle.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_dsize,
  input  logic        req_loadext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        write_reg;
  logic [1:0]  dsize_reg;
  logic        loadext_reg;
  logic [AW+1:0] addr_reg;
  logic [31:0] wdata_reg;

  logic        err;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lane;
  logic [31:0] rword;
  logic [31:0] load_data;
  logic [AW-1:0] word_idx;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW+2];
  assign word_idx       = addr_reg[AW+1:2];
  assign err            = misaligned(dsize_reg, addr_reg[1:0]);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_next   = 4'(LATENCY - 1);
          state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 4'd0;
      write_reg   <= 1'b0;
      dsize_reg   <= DSZ_BYTE;
      loadext_reg <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= 32'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == ST_IDLE && req_valid) begin
        write_reg   <= req_write;
        dsize_reg   <= req_dsize;
        loadext_reg <= req_loadext;
        addr_reg    <= req_addr[AW+1:0];
        wdata_reg   <= req_wdata;
      end
    end
  end

  dmem_lane_ctl u_lane_ctl (
    .dsize      (dsize_reg),
    .addr       (addr_reg[1:0]),
    .wdata      (wdata_reg),
    .loadext    (loadext_reg),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .load_data  (load_data)
  );

  // One array per byte lane so each lane has its own write enable; reads are
  // combinational so load data is available in the RESP cycle itself.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic       lane_we;

      assign lane_we = (state_reg == ST_RESP) && write_reg && !err && byte_en[gi];

      always_ff @(posedge clock) begin
        if (lane_we) lane_mem[word_idx] <= wdata_lane[8*gi +: 8];
      end

      assign rword[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_error = resp_valid && err;
  assign resp_rdata = (resp_valid && !write_reg && !err) ? load_data : 32'h0;
  assign stall      = ((state_reg == ST_IDLE) && req_valid) || (state_reg == ST_WAIT);

endmodule
